// File: rtl/morse_code_decoder_pkg.sv
// Shared types and constants for the Morse receive path: FSM states,
// PS/2 set-2 make codes and counter sizing.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_WORD_WAIT
    } state_e;

    localparam int MAX_SYMBOLS = 6;

    localparam logic [7:0]
        SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24,
        SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43, SC_J = 8'h3B,
        SC_K = 8'h42, SC_L = 8'h4B, SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44,
        SC_P = 8'h4D, SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C,
        SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22, SC_Y = 8'h35,
        SC_Z = 8'h1A;

    localparam logic [7:0]
        SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25,
        SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46;

    localparam logic [7:0] SC_SPACE = 8'h29;

    // Gap counter must reach the word threshold 5*DIT-1 without wrapping.
    function automatic int cnt_width(input int dit);
        return $clog2(5 * dit + 1);
    endfunction

endpackage

// File: rtl/morse_code_decoder_if.sv
// Decoded scan-code output bundle: data plus strobes, and the debounced key.
interface morse_code_decoder_if;
    logic [7:0] decoded_data;
    logic       decoded_data_strb;
    logic       error_strb;
    logic       key_db;

    modport master (output decoded_data, decoded_data_strb, error_strb, key_db);
    modport slave  (input  decoded_data, decoded_data_strb, error_strb, key_db);
endinterface

// File: rtl/morse_code_decoder_lookup.sv
// Combinational {len, pattern} -> set-2 make code table; first symbol sits at
// bit len-1, dit = 0, dah = 1.
module morse_lookup
    import morse_pkg::*;
(
    input  logic [8:0] len_pattern_i,
    output logic [7:0] code_o,
    output logic       hit_o
);

    always_comb begin
        code_o = 8'h00;
        hit_o  = 1'b1;
        case (len_pattern_i)
            9'b001_000000: code_o = SC_E;
            9'b001_000001: code_o = SC_T;
            9'b010_000000: code_o = SC_I;
            9'b010_000001: code_o = SC_A;
            9'b010_000010: code_o = SC_N;
            9'b010_000011: code_o = SC_M;
            9'b011_000000: code_o = SC_S;
            9'b011_000001: code_o = SC_U;
            9'b011_000010: code_o = SC_R;
            9'b011_000011: code_o = SC_W;
            9'b011_000100: code_o = SC_D;
            9'b011_000101: code_o = SC_K;
            9'b011_000110: code_o = SC_G;
            9'b011_000111: code_o = SC_O;
            9'b100_000000: code_o = SC_H;
            9'b100_000001: code_o = SC_V;
            9'b100_000010: code_o = SC_F;
            9'b100_000100: code_o = SC_L;
            9'b100_000110: code_o = SC_P;
            9'b100_000111: code_o = SC_J;
            9'b100_001000: code_o = SC_B;
            9'b100_001001: code_o = SC_X;
            9'b100_001010: code_o = SC_C;
            9'b100_001011: code_o = SC_Y;
            9'b100_001100: code_o = SC_Z;
            9'b100_001101: code_o = SC_Q;
            9'b101_000000: code_o = SC_5;
            9'b101_000001: code_o = SC_4;
            9'b101_000011: code_o = SC_3;
            9'b101_000111: code_o = SC_2;
            9'b101_001111: code_o = SC_1;
            9'b101_011111: code_o = SC_0;
            9'b101_010000: code_o = SC_6;
            9'b101_011000: code_o = SC_7;
            9'b101_011100: code_o = SC_8;
            9'b101_011110: code_o = SC_9;
            default:       hit_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_code_decoder.sv
// Morse key receiver: synchronise and debounce the key, time marks and gaps,
// and emit a set-2 make code (or an error) per completed character.
module morse_code_decoder
    import morse_pkg::*;
#(
    parameter int DIT_CYCLES      = 1_200_000,
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_in,
    morse_code_decoder_if.master  out_if
);

    localparam int             CW        = cnt_width(DIT_CYCLES);
    localparam int             DBW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  MARK_SAT  = CW'(2 * DIT_CYCLES);
    localparam logic [CW-1:0]  CHAR_END  = CW'(2 * DIT_CYCLES - 1);
    localparam logic [CW-1:0]  WORD_END  = CW'(5 * DIT_CYCLES - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]     MAX_LEN   = 3'(MAX_SYMBOLS);

    logic [1:0]     sync_q;
    logic [DBW-1:0] db_cnt_q;
    logic           key_db_q, key_prev_q;

    state_e         state_q, state_d;
    logic [CW-1:0]  mark_cnt_q, mark_cnt_d, gap_cnt_q, gap_cnt_d;
    logic [5:0]     pattern_q, pattern_d;
    logic [2:0]     len_q, len_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     data_q, data_d;
    logic           dstrb_q, dstrb_d, estrb_q, estrb_d;

    logic           rise, fall, is_dah, lk_hit;
    logic [7:0]     lk_code;

    // Debounce: the level is accepted once it has differed from key_db for
    // DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            key_db_q   <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_in};
            key_prev_q <= key_db_q;
            if (sync_q[1] == key_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                key_db_q <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DBW'(1);
            end
        end
    end

    assign rise   = key_db_q & ~key_prev_q;
    assign fall   = ~key_db_q & key_prev_q;
    assign is_dah = (mark_cnt_q >= MARK_SAT);

    morse_lookup u_lookup (
        .len_pattern_i ({len_q, pattern_q}),
        .code_o        (lk_code),
        .hit_o         (lk_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mark_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pattern_q  <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            data_q     <= 8'h00;
            dstrb_q    <= 1'b0;
            estrb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mark_cnt_q <= mark_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
            dstrb_q    <= dstrb_d;
            estrb_q    <= estrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        data_d     = data_q;
        dstrb_d    = 1'b0;
        estrb_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mark_cnt_d = '0;
                gap_cnt_d  = '0;
                pattern_d  = '0;
                len_d      = '0;
                ovf_d      = 1'b0;
                if (rise) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = CW'(1);
                end
            end
            ST_MARK: begin
                if (fall) begin
                    if (len_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        pattern_d = {pattern_q[4:0], is_dah};
                        len_d     = len_q + 3'd1;
                    end
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (mark_cnt_q != MARK_SAT) begin
                    mark_cnt_d = mark_cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + CW'(1);
                if (gap_cnt_q == CHAR_END) begin
                    if (lk_hit && !ovf_q) begin
                        data_d  = lk_code;
                        dstrb_d = 1'b1;
                    end else begin
                        estrb_d = 1'b1;
                    end
                    pattern_d = '0;
                    len_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_WORD_WAIT;
                end
                // A rise on the threshold cycle still emits, then starts a new mark.
                if (rise) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = CW'(1);
                end
            end
            ST_WORD_WAIT: begin
                gap_cnt_d = gap_cnt_q + CW'(1);
                if (gap_cnt_q == WORD_END) begin
                    data_d  = SC_SPACE;
                    dstrb_d = 1'b1;
                    state_d = ST_IDLE;
                end
                if (rise) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_if.decoded_data      = data_q;
    assign out_if.decoded_data_strb = dstrb_q;
    assign out_if.error_strb        = estrb_q;
    assign out_if.key_db            = key_db_q;

endmodule

// File: tb/tb_morse_code_decoder.sv
// Directed bench for morse_code_decoder with a timeline-based reference model
// (key history -> debounced level -> mark/gap durations -> character strings).
module tb_morse_code_decoder;

    localparam int DIT = 20;
    localparam int DEB = 4;
    localparam int HN  = DEB + 2;

    typedef struct {
        int         cyc;
        logic [7:0] code;
    } ev_t;

    logic clk, rst_n, key_in;
    morse_code_decoder_if u_if ();

    morse_code_decoder #(.DIT_CYCLES(DIT), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .out_if (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    string MTAB [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                         "--...", "---..", "----."};
    logic [7:0] CTAB [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h46};

    // reference model state
    logic       hist [HN];
    logic       m_kdb = 1'b0;
    int         rise_t = 0, fall_t = 0;
    bit         char_pend = 0, word_pend = 0;
    string      syms = "";
    logic [7:0] exp_data = 8'h00;
    logic       exp_dstrb = 1'b0, exp_estrb = 1'b0;

    ev_t dlog [$];
    ev_t elog [$];
    bit  kdb_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void lookup(input string s, output bit hit, output logic [7:0] code);
        hit  = 0;
        code = 8'h00;
        if (s.len() <= 6)
            for (int i = 0; i < 36; i++)
                if (s == MTAB[i]) begin
                    hit  = 1;
                    code = CTAB[i];
                end
    endfunction

    always @(posedge clk) begin
        bit         stable, hit;
        logic       nk;
        logic [7:0] code;
        cyc++;
        exp_dstrb = 1'b0;
        exp_estrb = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < HN; i++) hist[i] = 1'b0;
            m_kdb = 1'b0; char_pend = 0; word_pend = 0; syms = "";
            exp_data = 8'h00; rise_t = 0; fall_t = 0;
        end else begin
            for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = key_in;
            stable = 1;
            for (int i = 3; i < HN; i++) if (hist[i] != hist[2]) stable = 0;
            nk = stable ? hist[2] : m_kdb;
            if (nk && !m_kdb) begin
                if (char_pend && cyc < fall_t + 2*DIT) char_pend = 0;
                if (word_pend && cyc < fall_t + 5*DIT) word_pend = 0;
                rise_t = cyc;
            end
            if (!nk && m_kdb) begin
                syms = {syms, ((cyc - rise_t) >= 2*DIT) ? "-" : "."};
                fall_t = cyc;
                char_pend = 1;
                word_pend = 1;
            end
            if (char_pend && cyc == fall_t + 2*DIT + 1) begin
                lookup(syms, hit, code);
                if (hit) begin
                    exp_data  = code;
                    exp_dstrb = 1'b1;
                end else begin
                    exp_estrb = 1'b1;
                end
                syms = "";
                char_pend = 0;
            end
            if (word_pend && cyc == fall_t + 5*DIT + 1) begin
                exp_data  = 8'h29;
                exp_dstrb = 1'b1;
                word_pend = 0;
            end
            m_kdb = nk;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("key_db", u_if.key_db, m_kdb);
            chk("data_strb", u_if.decoded_data_strb, exp_dstrb);
            chk("error_strb", u_if.error_strb, exp_estrb);
            chk("decoded_data", u_if.decoded_data, exp_data);
            if (u_if.decoded_data_strb) dlog.push_back('{cyc, u_if.decoded_data});
            if (u_if.error_strb) elog.push_back('{cyc, u_if.decoded_data});
            if (u_if.key_db) kdb_hi = 1;
        end
    end

    task automatic hold(input logic lvl, input int n, output int t);
        key_in = lvl;
        t = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_logs();
        dlog.delete();
        elog.delete();
        kdb_hi = 0;
    endtask

    task automatic chk_codes(input string nm, input logic [7:0] c0, input logic [7:0] c1);
        chk({nm, "_ndata"}, dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk({nm, "_code0"}, dlog[0].code, c0);
            chk({nm, "_code1"}, dlog[1].code, c1);
        end
    endtask

    initial begin
        int p, q, t;
        rst_n = 1'b0;
        key_in = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_data", u_if.decoded_data, 8'h00);
        chk("rst_dstrb", u_if.decoded_data_strb, 1'b0);
        chk("rst_estrb", u_if.error_strb, 1'b0);
        chk("rst_kdb", u_if.key_db, 1'b0);
        rst_n = 1'b1;

        // E: single 20-cycle mark, then a word gap
        clr_logs();
        hold(1'b1, 20, p);
        hold(1'b0, 130, q);
        chk_codes("t1", 8'h24, 8'h29);
        chk("t1_nerr", elog.size(), 0);
        if (dlog.size() == 2) begin
            chk("t1_e_time", dlog[0].cyc, q + DEB + 1 + 41);
            chk("t1_sp_time", dlog[1].cyc, q + DEB + 1 + 101);
        end

        // A: dit, gap, dah
        clr_logs();
        hold(1'b1, 20, t);
        hold(1'b0, 20, t);
        hold(1'b1, 60, t);
        hold(1'b0, 130, t);
        chk_codes("t2", 8'h1C, 8'h29);
        chk("t2_nerr", elog.size(), 0);

        // seven dits overflow, then T before the word gap
        clr_logs();
        for (int i = 0; i < 7; i++) begin
            hold(1'b1, 20, t);
            hold(1'b0, (i == 6) ? 50 : 20, t);
        end
        hold(1'b1, 60, t);
        hold(1'b0, 130, t);
        chk("t3_nerr", elog.size(), 1);
        chk_codes("t3", 8'h2C, 8'h29);

        // ..-- is not in the table; data holds the previous space code
        clr_logs();
        hold(1'b1, 20, t); hold(1'b0, 20, t);
        hold(1'b1, 20, t); hold(1'b0, 20, t);
        hold(1'b1, 60, t); hold(1'b0, 20, t);
        hold(1'b1, 60, t); hold(1'b0, 130, t);
        chk("t4_nerr", elog.size(), 1);
        if (elog.size() == 1) chk("t4_held", elog[0].code, 8'h29);
        chk("t4_ndata", dlog.size(), 1);
        if (dlog.size() == 1) chk("t4_space", dlog[0].code, 8'h29);

        // short glitches never reach key_db
        clr_logs();
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 3, t);
            hold(1'b0, 10, t);
        end
        hold(1'b0, 20, t);
        chk("t5_kdb", kdb_hi, 1'b0);
        chk("t5_nevents", dlog.size() + elog.size(), 0);

        // reset mid-character discards the partial pattern
        clr_logs();
        hold(1'b1, 60, t); hold(1'b0, 20, t);
        hold(1'b1, 60, t); hold(1'b0, 12, t);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_data", u_if.decoded_data, 8'h00);
        chk("t6_dstrb", u_if.decoded_data_strb, 1'b0);
        chk("t6_estrb", u_if.error_strb, 1'b0);
        chk("t6_kdb", u_if.key_db, 1'b0);
        hold(1'b0, 130, t);
        chk("t6_nevents", dlog.size() + elog.size(), 0);
        hold(1'b1, 20, t);
        hold(1'b0, 130, t);
        chk_codes("t6", 8'h24, 8'h29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
